// File: rtl/seq_delay_monitor_pkg.sv
// Shared types and default parameters for the a-before-b delay monitor.
package seq_mon_pkg;

    // Outcome of the check evaluated on a single clock edge.
    typedef enum logic [1:0] {
        RES_NONE,
        RES_PASS,
        RES_FAIL
    } check_res_t;

    localparam int DEFAULT_DELAY = 2;
    localparam int DEFAULT_CW    = 16;
    localparam int DEFAULT_TW    = 32;

endpackage

// File: rtl/seq_delay_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_reg;

    // Count events, stopping at the maximum value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/seq_delay_monitor.sv
// Always-on checker for "b high implies a was high DELAY cycles earlier".
// Reports per-event pulses, saturating counts, a sticky error and the
// cycle index of the first failure.
module seq_delay_monitor
    import seq_mon_pkg::*;
#(
    parameter int DELAY = DEFAULT_DELAY,
    parameter int CW    = DEFAULT_CW,
    parameter int TW    = DEFAULT_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          a,
    input  logic          b,
    output logic          pass_pulse,
    output logic          fail_pulse,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          err_sticky,
    output logic [TW-1:0] first_fail_time
);

    // Warm-up counter only needs to reach DELAY.
    localparam int WW = $clog2(DELAY + 1);
    localparam logic [WW-1:0] WARM_DONE = WW'(DELAY);
    localparam logic [WW-1:0] WARM_ONE  = {{(WW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CYC_ONE   = {{(TW-1){1'b0}}, 1'b1};

    logic [DELAY-1:0] hist_reg;
    logic [DELAY-1:0] hist_next;
    logic [WW-1:0]    warm_reg;
    logic [TW-1:0]    cyc_cnt_reg;
    logic             hist_valid;
    check_res_t       res;
    logic             pass_evt;
    logic             fail_evt;
    logic             pass_pulse_reg;
    logic             fail_pulse_reg;
    logic             err_sticky_reg;
    logic [TW-1:0]    first_fail_time_reg;

    // Bit 0 takes the newest a; the top bit holds a from DELAY edges ago.
    assign hist_next[0] = a;
    generate
        for (genvar gi = 1; gi < DELAY; gi++) begin : g_hist
            assign hist_next[gi] = hist_reg[gi-1];
        end
    endgenerate

    // History, warm-up and cycle index advance on every edge, independent of en/clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg    <= '0;
            warm_reg    <= '0;
            cyc_cnt_reg <= '0;
        end else begin
            hist_reg    <= hist_next;
            cyc_cnt_reg <= cyc_cnt_reg + CYC_ONE;
            if (warm_reg != WARM_DONE) begin
                warm_reg <= warm_reg + WARM_ONE;
            end
        end
    end

    assign hist_valid = (warm_reg == WARM_DONE);

    // Evaluate this edge's check; a clear on the same edge swallows the event.
    always_comb begin
        res = RES_NONE;
        if (b && en && hist_valid) begin
            res = hist_reg[DELAY-1] ? RES_PASS : RES_FAIL;
        end
        pass_evt = (res == RES_PASS) && !clr;
        fail_evt = (res == RES_FAIL) && !clr;
    end

    // Registered one-cycle result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_pulse_reg <= 1'b0;
            fail_pulse_reg <= 1'b0;
        end else begin
            pass_pulse_reg <= pass_evt;
            fail_pulse_reg <= fail_evt;
        end
    end

    // Sticky error flag and timestamp of the first failure since rst/clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_sticky_reg      <= 1'b0;
            first_fail_time_reg <= '0;
        end else if (fail_evt && !err_sticky_reg) begin
            err_sticky_reg      <= 1'b1;
            first_fail_time_reg <= cyc_cnt_reg;
        end
    end

    sat_counter #(.W(CW)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pass_evt),
        .clr (clr),
        .cnt (pass_cnt)
    );

    sat_counter #(.W(CW)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .inc (fail_evt),
        .clr (clr),
        .cnt (fail_cnt)
    );

    assign pass_pulse      = pass_pulse_reg;
    assign fail_pulse      = fail_pulse_reg;
    assign err_sticky      = err_sticky_reg;
    assign first_fail_time = first_fail_time_reg;

endmodule
